ifetch_buf: RTL and testbench

Instruction-fetch buffer sitting directly downstream of the PC/next-PC register and upstream of decode. It issues the current PC to the synchronous instruction memory, captures the returned word one cycle later, and queues {pc, instr} pairs in a small FIFO. Decode drains the FIFO through a valid/ready handshake. The block back-pressures the PC register through its stall input and discards all wrong-path work on a redirect flush.

---
 rtl/ifetch_buf.sv | 104 ++++++++++
 tb/tb_ifetch_buf.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_buf.sv
// Instruction-fetch buffer: issues PC to sync imem, queues {pc, instr} for decode.
// Optional misaligned-fetch flagging is enabled by defining IFB_MISALIGN_CHECK_EN.
module ifetch_buf #(
   parameter int unsigned DEPTH     = 2,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [31:0]              pc,
   output logic                     stall_out,
   input  logic                     flush,
   output logic [31:0]              imem_addr,
   input  logic [31:0]              imem_rdata,
   output logic                     id_valid,
   input  logic                     id_ready,
   output logic [31:0]              id_pc,
   output logic [31:0]              id_instr,
   output logic                     id_exc,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int unsigned PW  = $clog2(DEPTH);
   localparam int unsigned CW  = PW + 1;
   localparam int unsigned CW1 = CW + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic            infl_v;
   logic [31:0]     infl_pc;
   logic            pop;
   logic            push;
   logic            issue;
   logic [CW1-1:0]  credit;
   logic            not_empty;

   assign imem_addr = pc;
   assign not_empty = (count != '0);
   assign id_valid  = not_empty & ~flush;
   assign pop       = id_valid & id_ready;
   assign push      = infl_v & ~flush;

   // Credit check reserves a slot for the fetch already in flight.
   assign credit    = {1'b0, count} + CW1'(infl_v) - CW1'(pop);
   assign stall_out = ~flush & (credit >= CW1'(DEPTH));
   assign issue     = ~stall_out & ~flush;
   assign occupancy = count;

   assign id_pc     = not_empty ? mem[rd_ptr].pc    : 32'h0;
   assign id_instr  = not_empty ? mem[rd_ptr].instr : NOP_INSTR;

   // Pointers, occupancy and in-flight tracking; flush wins over push/pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         infl_v  <= 1'b0;
         infl_pc <= 32'h0;
      end else begin
         infl_v  <= issue;
         infl_pc <= pc;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   // Entry storage needs no reset; count gates visibility.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {infl_pc, imem_rdata};
   end

`ifdef IFB_MISALIGN_CHECK_EN
   logic infl_exc;
   logic exc_mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) infl_exc <= 1'b0;
      else        infl_exc <= (pc[1:0] != 2'b00);
   end

   always_ff @(posedge clk) begin
      if (push) exc_mem[wr_ptr] <= infl_exc;
   end

   assign id_exc = not_empty & exc_mem[rd_ptr];
`else
   assign id_exc = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_buf.sv
// Self-checking bench for ifetch_buf: directed scenarios plus randomized run
// against a queue-based reference model, PC-register model and sync imem model.
module tb_ifetch_buf;

   localparam int          DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IFB_MISALIGN_CHECK_EN
   localparam bit EXC_EN = 1'b1;
`else
   localparam bit EXC_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc;
   logic        stall_out;
   logic        flush;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_exc;
   logic [1:0]  occupancy;

   ifetch_buf #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .pc(pc), .stall_out(stall_out), .flush(flush),
      .imem_addr(imem_addr), .imem_rdata(imem_rdata), .id_valid(id_valid),
      .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr), .id_exc(id_exc),
      .occupancy(occupancy)
   );

   initial forever #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        exc;
   } ent_t;

   ent_t        mq[$];
   bit          m_infl;
   logic [31:0] m_infl_pc;
   bit          m_infl_exc;
   logic [31:0] prev_pc;
   logic [31:0] tgt_r;
   bit          exp_valid, exp_stall, exp_exc;
   logic [31:0] exp_pc, exp_instr;
   int          exp_occ;
   int          n_checks = 0;
   int          n_fail   = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
   endfunction

   function automatic bit misal(input logic [31:0] a);
      return EXC_EN && (a[1:0] != 2'b00);
   endfunction

   // Apply one cycle of inputs (at negedge) and compute the model's expectations.
   task automatic drive(input bit f, input bit r, input logic [31:0] tgt);
      bit pop;
      flush      = f;
      id_ready   = r;
      tgt_r      = tgt;
      imem_rdata = mem_word(prev_pc);
      exp_occ    = mq.size();
      exp_valid  = (mq.size() != 0) && !f;
      pop        = exp_valid && r;
      exp_stall  = !f && ((mq.size() + int'(m_infl) - int'(pop)) >= DEPTH);
      if (mq.size() != 0) begin
         exp_pc = mq[0].pc; exp_instr = mq[0].instr; exp_exc = mq[0].exc;
      end else begin
         exp_pc = 32'h0; exp_instr = NOP; exp_exc = 1'b0;
      end
      #1;
   endtask

   // Clock the cycle, then update model and the PC register at the next negedge.
   task automatic advance();
      bit pop;
      pop = exp_valid && id_ready;
      @(posedge clk);
      @(negedge clk);
      if (flush) begin
         mq.delete();
         m_infl = 1'b0;
      end else begin
         if (pop) mq.delete(0);
         if (m_infl) mq.push_back('{pc: m_infl_pc, instr: imem_rdata, exc: m_infl_exc});
         m_infl     = !exp_stall;
         m_infl_pc  = pc;
         m_infl_exc = misal(pc);
      end
      prev_pc = pc;
      if (flush)           pc = tgt_r;
      else if (!exp_stall) pc = pc + 32'd4;
   endtask

   task automatic model_clear();
      mq.delete();
      m_infl     = 1'b0;
      m_infl_pc  = 32'h0;
      m_infl_exc = 1'b0;
      prev_pc    = 32'h0;
      pc         = 32'h0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; flush = 1'b0; id_ready = 1'b0; imem_rdata = 32'h0;
      model_clear();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; id_ready = 1'b1; pc = 32'h0; imem_rdata = 32'h0;
      #1;
      n_checks++; if (id_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid got %b exp 0", id_valid); end
      n_checks++; if (stall_out !== 1'b0)  begin n_fail++; $display("FAIL reset_stall got %b exp 0", stall_out); end
      n_checks++; if (occupancy !== 2'd0)  begin n_fail++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
      n_checks++; if (id_instr !== NOP)    begin n_fail++; $display("FAIL reset_instr got %h exp %h", id_instr, NOP); end
      n_checks++; if (id_pc !== 32'h0)     begin n_fail++; $display("FAIL reset_pc got %h exp 0", id_pc); end
      n_checks++; if (id_exc !== 1'b0)     begin n_fail++; $display("FAIL reset_exc got %b exp 0", id_exc); end
   endtask

   task automatic test_stream();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, 32'h0);
         if (i == 0) begin
            n_checks++; if (imem_addr !== pc) begin n_fail++; $display("FAIL stream_addr got %h exp %h", imem_addr, pc); end
         end
         n_checks++; if (id_valid !== (i >= 2)) begin n_fail++; $display("FAIL stream_valid cyc %0d got %b exp %b", i, id_valid, i >= 2); end
         n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL stream_stall cyc %0d got %b exp 0", i, stall_out); end
         if (i >= 2) begin
            n_checks++; if (id_pc !== 32'((i - 2) * 4)) begin n_fail++; $display("FAIL stream_pc cyc %0d got %h exp %h", i, id_pc, 32'((i - 2) * 4)); end
            n_checks++; if (id_instr !== mem_word(32'((i - 2) * 4))) begin n_fail++; $display("FAIL stream_instr cyc %0d got %h exp %h", i, id_instr, mem_word(32'((i - 2) * 4))); end
            n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occ cyc %0d got %0d exp 1", i, occupancy); end
         end
         advance();
      end
   endtask

   task automatic test_backpressure();
      bit       st_e  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      int       occ_e [4] = '{0, 0, 1, 2};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 32'h0);
         n_checks++; if (stall_out !== st_e[i]) begin n_fail++; $display("FAIL bp_stall cyc %0d got %b exp %b", i, stall_out, st_e[i]); end
         n_checks++; if (occupancy !== 2'(occ_e[i])) begin n_fail++; $display("FAIL bp_occ cyc %0d got %0d exp %0d", i, occupancy, occ_e[i]); end
         advance();
      end
      drive(1'b0, 1'b1, 32'h0);
      n_checks++; if (id_pc !== 32'h0)   begin n_fail++; $display("FAIL bp_head got %h exp 0", id_pc); end
      n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL bp_release_stall got %b exp 0", stall_out); end
      advance();
      drive(1'b0, 1'b0, 32'h0);
      n_checks++; if (id_pc !== 32'h4)   begin n_fail++; $display("FAIL bp_next got %h exp 4", id_pc); end
      n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL bp_occ_after got %0d exp 1", occupancy); end
      advance();
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 32'h0);
         advance();
      end
      drive(1'b1, 1'b0, 32'h40);
      n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b exp 0", stall_out); end
      n_checks++; if (id_valid !== 1'b0)  begin n_fail++; $display("FAIL flush_valid_F got %b exp 0", id_valid); end
      advance();
      for (int i = 1; i <= 4; i++) begin
         drive(1'b0, 1'b1, 32'h0);
         n_checks++; if (id_valid !== (i >= 3)) begin n_fail++; $display("FAIL flush_valid F+%0d got %b exp %b", i, id_valid, i >= 3); end
         if (i == 1) begin
            n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occ got %0d exp 0", occupancy); end
         end
         if (i >= 3) begin
            n_checks++; if (id_pc !== 32'h40 + 32'((i - 3) * 4)) begin n_fail++; $display("FAIL flush_target F+%0d got %h exp %h", i, id_pc, 32'h40 + 32'((i - 3) * 4)); end
         end
         advance();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 32'h0);
         advance();
      end
      drive(1'b0, 1'b0, 32'h0);
      n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL mid_pre_occ got %0d exp 2", occupancy); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL mid_occ got %0d exp 0", occupancy); end
      n_checks++; if (id_valid !== 1'b0)  begin n_fail++; $display("FAIL mid_valid got %b exp 0", id_valid); end
      n_checks++; if (id_instr !== NOP)   begin n_fail++; $display("FAIL mid_instr got %h exp %h", id_instr, NOP); end
      n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL mid_stall got %b exp 0", stall_out); end
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 32'h0);
         if (i == 2) begin
            n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin n_fail++; $display("FAIL mid_restart got v=%b pc=%h exp v=1 pc=0", id_valid, id_pc); end
         end
         advance();
      end
   endtask

   task automatic test_misalign();
      do_reset();
      drive(1'b1, 1'b1, 32'h102);
      advance();
      for (int i = 1; i <= 3; i++) begin
         drive(1'b0, 1'b1, 32'h0);
         if (i == 3) begin
            n_checks++; if (id_pc !== 32'h102) begin n_fail++; $display("FAIL mis_pc got %h exp 102", id_pc); end
            n_checks++; if (id_exc !== EXC_EN) begin n_fail++; $display("FAIL mis_exc got %b exp %b", id_exc, EXC_EN); end
         end
         advance();
      end
   endtask

   task automatic test_random();
      bit          f, r;
      logic [31:0] tgt;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         f   = ($urandom_range(0, 15) == 0);
         r   = ($urandom_range(0, 3) != 0);
         tgt = 32'h1000 + 32'($urandom_range(0, 1023));
         drive(f, r, tgt);
         n_checks++; if (id_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, id_valid, exp_valid); end
         n_checks++; if (stall_out !== exp_stall) begin n_fail++; $display("FAIL rnd_stall cyc %0d got %b exp %b", i, stall_out, exp_stall); end
         n_checks++; if (occupancy !== 2'(exp_occ)) begin n_fail++; $display("FAIL rnd_occ cyc %0d got %0d exp %0d", i, occupancy, exp_occ); end
         n_checks++; if (id_pc !== exp_pc) begin n_fail++; $display("FAIL rnd_pc cyc %0d got %h exp %h", i, id_pc, exp_pc); end
         n_checks++; if (id_instr !== exp_instr) begin n_fail++; $display("FAIL rnd_instr cyc %0d got %h exp %h", i, id_instr, exp_instr); end
         n_checks++; if (id_exc !== exp_exc) begin n_fail++; $display("FAIL rnd_exc cyc %0d got %b exp %b", i, id_exc, exp_exc); end
         advance();
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_misalign();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
